// File: rtl/cdc_pulse_sync_rx.sv
// Destination-side receiver for toggle-encoded pulse crossings: synchronises each
// toggle line, turns every transition into a queued event and returns the level as an ack.
module cdc_pulse_sync_rx #(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3,
    parameter int READY_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req_tgl,
    input  logic [NUM_CH-1:0]       evt_ready,
    input  logic [NUM_CH-1:0]       ovf_clr,
    output logic [NUM_CH-1:0]       evt_valid,
    output logic [NUM_CH*CNT_W-1:0] evt_count,
    output logic [NUM_CH-1:0]       ack_tgl,
    output logic [NUM_CH-1:0]       ovf
);

    localparam logic             IGNORE_READY = (READY_EN == 0);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    // Handshake: an event is consumed on a cycle where evt_valid[ch] and
    // (evt_ready[ch] or pulse mode) are both high; evt_valid comes straight from
    // the counter register, so it never depends combinationally on evt_ready.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   lvl_q;
        logic                   edge_det;
        logic                   pop;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       cnt_d;
        logic                   ovf_q;
        logic                   ovf_d;

        assign edge_det = sync_q[SYNC_STAGES-1] ^ lvl_q;
        assign pop      = (cnt_q != '0) & (evt_ready[ch] | IGNORE_READY);

        // A simultaneous edge and pop cancel out, so a full counter is not an overflow then.
        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q & ~ovf_clr[ch];
            if (edge_det && !pop) begin
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (!edge_det && pop) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
                lvl_q  <= 1'b0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl[ch]};
                lvl_q  <= sync_q[SYNC_STAGES-1];
                cnt_q  <= cnt_d;
                ovf_q  <= ovf_d;
            end
        end

        assign evt_valid[ch]                = (cnt_q != '0);
        assign evt_count[ch*CNT_W +: CNT_W] = cnt_q;
        assign ack_tgl[ch]                  = lvl_q;
        assign ovf[ch]                      = ovf_q;
    end

endmodule
